// File: rtl/shift_link_pkg.sv
// Shared types and constants for the shift link controller and its shift core.
package shift_link_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        SHIFT_TX = 2'b01,
        SHIFT_RX = 2'b10,
        RX_HOLD  = 2'b11
    } state_t;

    typedef enum logic {
        GRANT_TX = 1'b0,
        GRANT_RX = 1'b1
    } grant_t;

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

endpackage

// File: rtl/shift_link_if.sv
// Word-side handshakes and serial pins of the shift link controller.
interface shift_link_if #(
    parameter int N = 8
);

    logic [N-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         rx_req;
    logic         sin;
    logic [N-1:0] rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic         sout;
    logic         sen;
    logic         busy;

    modport master (
        output tx_data, tx_valid, rx_req, sin, rx_ready,
        input  tx_ready, rx_data, rx_valid, sout, sen, busy
    );

    modport slave (
        input  tx_data, tx_valid, rx_req, sin, rx_ready,
        output tx_ready, rx_data, rx_valid, sout, sen, busy
    );

endinterface

// File: rtl/shift_link_ctrl_shift_core.sv
// N-bit universal shift register: hold, right shift, left shift, parallel load.
module shift_core
    import shift_link_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   i_s,
    input  logic [N-1:0] i_d,
    input  logic         i_lin,
    input  logic         i_rin,
    output logic [N-1:0] o_q
);

    logic [N-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else begin
            case (i_s)
                MODE_RIGHT: r_q <= {i_rin, r_q[N-1:1]};
                MODE_LEFT:  r_q <= {r_q[N-2:0], i_lin};
                MODE_LOAD:  r_q <= i_d;
                default:    r_q <= r_q;
            endcase
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/shift_link_ctrl.sv
// Round-robin TX/RX controller sequencing one shared shift register, MSB first
// in both directions.
module shift_link_ctrl
    import shift_link_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    shift_link_if.slave  bus
);

    localparam int CW = $clog2(N);

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    grant_t         r_lastGrant;

    state_t         w_nextState;
    logic [CW-1:0]  w_nextCnt;
    grant_t         w_nextLastGrant;
    logic [1:0]     w_mode;
    logic           w_lin;
    logic [N-1:0]   w_q;
    logic           w_grantTx;
    logic           w_grantRx;
    logic           w_lastBit;

    // On a tie the requester that did not win last time is served.
    assign w_grantTx = bus.tx_valid && (!bus.rx_req || (r_lastGrant == GRANT_RX));
    assign w_grantRx = bus.rx_req && (!bus.tx_valid || (r_lastGrant == GRANT_TX));
    assign w_lastBit = (r_cnt == CW'(N - 1));

    shift_core #(.N(N)) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .i_s   (w_mode),
        .i_d   (bus.tx_data),
        .i_lin (w_lin),
        .i_rin (1'b0),
        .o_q   (w_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_lastGrant <= GRANT_RX;
        end else begin
            r_state     <= w_nextState;
            r_cnt       <= w_nextCnt;
            r_lastGrant <= w_nextLastGrant;
        end
    end

    always_comb begin
        w_nextState     = r_state;
        w_nextCnt       = r_cnt;
        w_nextLastGrant = r_lastGrant;
        w_mode          = MODE_HOLD;
        w_lin           = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grantTx) begin
                    w_mode          = MODE_LOAD;
                    w_nextCnt       = '0;
                    w_nextState     = SHIFT_TX;
                    w_nextLastGrant = GRANT_TX;
                end else if (w_grantRx) begin
                    w_nextCnt       = '0;
                    w_nextState     = SHIFT_RX;
                    w_nextLastGrant = GRANT_RX;
                end
            end
            SHIFT_TX: begin
                w_mode    = MODE_LEFT;
                w_nextCnt = r_cnt + CW'(1);
                if (w_lastBit) w_nextState = IDLE;
            end
            SHIFT_RX: begin
                w_mode    = MODE_LEFT;
                w_lin     = bus.sin;
                w_nextCnt = r_cnt + CW'(1);
                if (w_lastBit) w_nextState = RX_HOLD;
            end
            RX_HOLD: begin
                if (bus.rx_ready) w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    assign bus.tx_ready = (r_state == IDLE) && w_grantTx;
    assign bus.sen      = (r_state == SHIFT_TX);
    assign bus.sout     = (r_state == SHIFT_TX) && w_q[N-1];
    assign bus.rx_valid = (r_state == RX_HOLD);
    assign bus.rx_data  = w_q;
    assign bus.busy     = (r_state != IDLE);

endmodule

// File: tb/tb_shift_link_ctrl.sv
// Directed self-checking bench for shift_link_ctrl with hand-computed vectors.
module tb_shift_link_ctrl;

    logic clk;
    logic rst_n;
    int   checkCount;
    int   errorCount;

    shift_link_if #(.N(8)) bus ();

    shift_link_ctrl #(.N(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic txValid, input logic [7:0] txData,
                                 input logic rxReq, input logic sinBit, input logic rxReady);
        bus.tx_valid = txValid;
        bus.tx_data  = txData;
        bus.rx_req   = rxReq;
        bus.sin      = sinBit;
        bus.rx_ready = rxReady;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        nextCycle();
        nextCycle();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] word;
        int         grants;
        int         violations;
        logic       order [4];

        checkCount = 0;
        errorCount = 0;
        rst_n      = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        applyReset();
        #1;
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_sen", bus.sen, 0);
        checkOutput("rst_sout", bus.sout, 0);
        checkOutput("rst_rx_valid", bus.rx_valid, 0);
        checkOutput("rst_rx_data", bus.rx_data, 0);

        // TX A5: ready in the handshake cycle, then eight bits MSB first
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("tx_ready_a5", bus.tx_ready, 1);
        nextCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        word = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            #1;
            checkOutput("tx_a5_sen", bus.sen, 1);
            checkOutput("tx_a5_sout", bus.sout, word[7-i]);
            nextCycle();
        end
        #1;
        checkOutput("tx_a5_done_busy", bus.busy, 0);
        checkOutput("tx_a5_done_sen", bus.sen, 0);

        // RX CA with rx_ready already high: rx_valid for exactly one cycle
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        #1;
        checkOutput("rx_ca_grant_idle", bus.busy, 0);
        nextCycle();
        word = 8'hCA;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, word[7-i], 1'b1);
            #1;
            checkOutput("rx_ca_no_valid", bus.rx_valid, 0);
            nextCycle();
        end
        #1;
        checkOutput("rx_ca_valid", bus.rx_valid, 1);
        checkOutput("rx_ca_data", bus.rx_data, 32'hCA);
        nextCycle();
        #1;
        checkOutput("rx_ca_valid_drop", bus.rx_valid, 0);
        checkOutput("rx_ca_idle", bus.busy, 0);

        // Both requesting from reset: TX, RX, TX, RX
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        applyReset();
        applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0, 1'b1);
        grants     = 0;
        violations = 0;
        for (int c = 0; c < 80 && grants < 4; c++) begin
            #1;
            if (bus.busy && bus.tx_ready) violations++;
            if (!bus.busy) begin
                order[grants] = bus.tx_ready ? 1'b0 : 1'b1;
                grants++;
            end
            nextCycle();
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("tie_grant_count", grants, 4);
        checkOutput("tie_order0_tx", order[0], 0);
        checkOutput("tie_order1_rx", order[1], 1);
        checkOutput("tie_order2_tx", order[2], 0);
        checkOutput("tie_order3_rx", order[3], 1);
        checkOutput("tie_ready_when_busy", violations, 0);
        for (int c = 0; c < 20 && bus.busy; c++) nextCycle();
        #1;
        checkOutput("tie_drain", bus.busy, 0);

        // RX 3C held in RX_HOLD for 5 cycles while TX waits
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        nextCycle();
        word = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(i >= 3, 8'h96, 1'b0, word[7-i], 1'b0);
            #1;
            checkOutput("rx_3c_tx_blocked", bus.tx_ready, 0);
            nextCycle();
        end
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("hold_valid", bus.rx_valid, 1);
            checkOutput("hold_data", bus.rx_data, 32'h3C);
            checkOutput("hold_no_tx_ready", bus.tx_ready, 0);
            checkOutput("hold_no_sen", bus.sen, 0);
            nextCycle();
        end
        bus.rx_ready = 1'b1;
        #1;
        checkOutput("hold_release_valid", bus.rx_valid, 1);
        nextCycle();
        bus.rx_ready = 1'b0;
        #1;
        checkOutput("post_hold_idle", bus.busy, 0);
        checkOutput("post_hold_tx_ready", bus.tx_ready, 1);
        nextCycle();
        bus.tx_valid = 1'b0;
        #1;
        checkOutput("post_hold_tx_sen", bus.sen, 1);
        checkOutput("post_hold_tx_bit7", bus.sout, 1);
        for (int i = 0; i < 8; i++) nextCycle();
        #1;
        checkOutput("post_hold_tx_done", bus.busy, 0);

        // Reset at bit 4 of FF aborts the frame; tie-break restarts at TX
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("tx_ff_ready", bus.tx_ready, 1);
        nextCycle();
        bus.tx_valid = 1'b0;
        for (int i = 0; i < 4; i++) nextCycle();
        #1;
        checkOutput("tx_ff_bit4_sen", bus.sen, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_sen", bus.sen, 0);
        checkOutput("abort_sout", bus.sout, 0);
        checkOutput("abort_busy", bus.busy, 0);
        checkOutput("abort_data", bus.rx_data, 0);
        nextCycle();
        rst_n = 1'b1;
        applyStimulus(1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("abort_tie_tx_first", bus.tx_ready, 1);
        nextCycle();

        // TX 01 with tx_valid dropped right after the handshake
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        word = 8'h01;
        for (int i = 0; i < 8; i++) begin
            #1;
            checkOutput("tx_01_sen", bus.sen, 1);
            checkOutput("tx_01_sout", bus.sout, word[7-i]);
            nextCycle();
        end
        #1;
        checkOutput("tx_01_done", bus.busy, 0);
        checkOutput("tx_01_sout_idle", bus.sout, 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
